conv_wr_pack: RTL and testbench

Upstream feeder for the Avalon write master in the convolution result path. Accepts a stream of 32-bit conv results, packs four words per 128-bit beat, issues one write-master transfer covering the whole result block, and pushes beats into the write master's buffer under its almost-full back-pressure. Reports completion only after the write master signals done.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/wr_beat_pack.sv | 67 ++++++
 rtl/conv_wr_pack.sv | 138 +++++++++++++
 tb/tb_conv_wr_pack.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution result write path.
package conv_pkg;

  localparam int LANES      = 4;
  localparam int BEAT_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_STREAM,
    ST_FLUSH,
    ST_WAIT_DONE
  } wr_pack_state_t;

  // Bytes covered by a block of 'words' results, rounded up to whole beats.
  function automatic logic [31:0] block_bytes(input logic [31:0] words);
    logic [31:0] beats;
    beats = (words + 32'd3) >> 2;
    return beats * 32'(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/wr_beat_pack.sv
// Packs DW-bit words into BW-bit beats, lane 0 in the low bits; emits a
// registered one-cycle push per full or flushed (zero-padded) beat.
module wr_beat_pack #(
  parameter int DW = 32,
  parameter int BW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept_i,
  input  logic [DW-1:0] data_i,
  input  logic          flush_i,
  output logic          last_lane_o,
  output logic          push_o,
  output logic [BW-1:0] beat_o
);

  localparam int LANES_L = BW / DW;
  localparam int LW      = $clog2(LANES_L);

  logic [LW-1:0] lane_q, lane_d;
  logic [BW-1:0] lanes_q, lanes_d;
  logic          push_q, push_d;
  logic [BW-1:0] beat_q, beat_d;

  assign last_lane_o = (lane_q == LW'(LANES_L - 1));
  assign push_o      = push_q;
  assign beat_o      = beat_q;

  // Lanes are cleared on every push so a flush naturally zero-pads.
  always_comb begin
    lane_d  = lane_q;
    lanes_d = lanes_q;
    push_d  = 1'b0;
    beat_d  = beat_q;
    if (accept_i) begin
      if (last_lane_o) begin
        beat_d  = {data_i, lanes_q[BW-DW-1:0]};
        push_d  = 1'b1;
        lanes_d = '0;
        lane_d  = '0;
      end else begin
        lanes_d[lane_q*DW +: DW] = data_i;
        lane_d = lane_q + 1'b1;
      end
    end else if (flush_i) begin
      beat_d  = lanes_q;
      push_d  = 1'b1;
      lanes_d = '0;
      lane_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      lanes_q <= '0;
      push_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
      push_q  <= push_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: rtl/conv_wr_pack.sv
// Feeds the Avalon write master: one transfer per result block, beats pushed
// under almost-full back-pressure, completion after a low-then-high wm_done.
//
// Handshake: a word moves when in_valid & in_ready are both high on a rising
// clock edge; in_ready never depends on in_valid, and in_valid may drop at will.
module conv_wr_pack
  import conv_pkg::*;
#(
  parameter int DW = 32,
  parameter int BW = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic [31:0]    cfg_base,
  input  logic [31:0]    cfg_words,
  output logic           cfg_busy,
  output logic           cfg_done,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_data,
  output logic           in_ready,
  output logic           wm_fixed_location,
  output logic [31:0]    wm_base,
  output logic [31:0]    wm_length,
  output logic           wm_go,
  input  logic           wm_done,
  output logic           wm_write_buffer,
  output logic [BW-1:0]  wm_buffer_data,
  input  logic           wm_buffer_full,
  output wr_pack_state_t dbg_state
);

  wr_pack_state_t state_q, state_d;
  logic [31:0]    base_q, base_d;
  logic [31:0]    length_q, length_d;
  logic [31:0]    words_left_q, words_left_d;
  logic           seen_low_q, seen_low_d;
  logic           done_q, done_d;
  logic           accept;
  logic           flush;
  logic           last_lane;

  assign in_ready = (state_q == ST_STREAM) && !wm_buffer_full && (words_left_q != '0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    length_d     = length_q;
    words_left_d = words_left_q;
    seen_low_d   = seen_low_q;
    done_d       = 1'b0;
    flush        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_words == '0) begin
            done_d = 1'b1;
          end else begin
            base_d       = cfg_base & 32'hFFFF_FFF0;
            length_d     = block_bytes(cfg_words);
            words_left_d = cfg_words;
            state_d      = ST_GO;
          end
        end
      end
      ST_GO: begin
        seen_low_d = 1'b0;
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        // wm_done is still high from the previous transfer right after go.
        seen_low_d = seen_low_q | ~wm_done;
        if (accept) begin
          words_left_d = words_left_q - 32'd1;
          if (words_left_q == 32'd1) begin
            state_d = last_lane ? ST_WAIT_DONE : ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        seen_low_d = seen_low_q | ~wm_done;
        flush      = 1'b1;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        seen_low_d = seen_low_q | ~wm_done;
        if (seen_low_q && wm_done) begin
          done_d     = 1'b1;
          seen_low_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      length_q     <= '0;
      words_left_q <= '0;
      seen_low_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      length_q     <= length_d;
      words_left_q <= words_left_d;
      seen_low_q   <= seen_low_d;
      done_q       <= done_d;
    end
  end

  wr_beat_pack #(
    .DW(DW),
    .BW(BW)
  ) u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_i   (accept),
    .data_i     (in_data),
    .flush_i    (flush),
    .last_lane_o(last_lane),
    .push_o     (wm_write_buffer),
    .beat_o     (wm_buffer_data)
  );

  assign cfg_busy          = (state_q != ST_IDLE);
  assign cfg_done          = done_q;
  assign wm_go             = (state_q == ST_GO);
  assign wm_base           = base_q;
  assign wm_length         = length_q;
  assign wm_fixed_location = 1'b0;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_conv_wr_pack.sv
// Bench for conv_wr_pack: randomized blocks against a beat-level model,
// write-master done behaviour, back-pressure and mid-block reset.
module tb_conv_wr_pack;
  import conv_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_start;
  logic [31:0]    cfg_base;
  logic [31:0]    cfg_words;
  logic           cfg_busy;
  logic           cfg_done;
  logic           in_valid;
  logic [31:0]    in_data;
  logic           in_ready;
  logic           wm_fixed_location;
  logic [31:0]    wm_base;
  logic [31:0]    wm_length;
  logic           wm_go;
  logic           wm_done;
  logic           wm_write_buffer;
  logic [127:0]   wm_buffer_data;
  logic           wm_buffer_full;
  wr_pack_state_t dbg_state;

  conv_wr_pack #(.DW(32), .BW(128)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_base         (cfg_base),
    .cfg_words        (cfg_words),
    .cfg_busy         (cfg_busy),
    .cfg_done         (cfg_done),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .wm_fixed_location(wm_fixed_location),
    .wm_base          (wm_base),
    .wm_length        (wm_length),
    .wm_go            (wm_go),
    .wm_done          (wm_done),
    .wm_write_buffer  (wm_write_buffer),
    .wm_buffer_data   (wm_buffer_data),
    .wm_buffer_full   (wm_buffer_full),
    .dbg_state        (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int go_count = 0;
  int push_count = 0;
  int done_count = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  wq[$];
  logic [31:0]  exp_base;
  logic [31:0]  exp_len;
  logic [127:0] exp_beat;

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wm_write_buffer) begin
        push_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL push_extra got=%h want=no_push", wm_buffer_data);
        end else begin
          exp_beat = exp_q.pop_front();
          if (wm_buffer_data !== exp_beat) begin
            failures++;
            $display("FAIL beat_data got=%h want=%h", wm_buffer_data, exp_beat);
          end
        end
      end
      if (wm_go) begin
        go_count++;
        checks++;
        if (wm_base !== exp_base || wm_length !== exp_len || wm_fixed_location !== 1'b0) begin
          failures++;
          $display("FAIL go_params got base=%h len=%0d want base=%h len=%0d",
                   wm_base, wm_length, exp_base, exp_len);
        end
      end
      if (cfg_done) done_count++;
      if (wm_buffer_full) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_under_full got=%b want=0", in_ready);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats from the block rules: word k in lane k%4, tail zero-padded.
  task automatic build_model(input logic [31:0] base, input int n);
    logic [127:0] beat;
    exp_base = base & 32'hFFFF_FFF0;
    exp_len  = 32'(((n + 3) / 4) * 16);
    for (int b = 0; b < (n + 3) / 4; b++) begin
      beat = '0;
      for (int l = 0; l < 4; l++) begin
        if (b * 4 + l < n) beat[l*32 +: 32] = wq[b*4 + l];
      end
      exp_q.push_back(beat);
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [31:0] words);
    cfg_start = 1'b1;
    cfg_base  = base;
    cfg_words = words;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic drive_words(input int stall_at, input int limit);
    int  i;
    int  budget;
    int  p0;
    bit  acc;
    bit  stalled;
    i = 0;
    budget = 0;
    stalled = 1'b0;
    while (i < limit && budget < 3000) begin
      if (i == stall_at && !stalled) begin
        stalled = 1'b1;
        in_valid = 1'b1;
        in_data = wq[i];
        wm_buffer_full = 1'b1;
        p0 = push_count;
        repeat (10) step();
        checks++;
        if (push_count - p0 > 1) begin
          failures++;
          $display("FAIL stall_pushes got=%0d want<=1", push_count - p0);
        end
        wm_buffer_full = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
        budget++;
      end else begin
        in_valid = 1'b1;
        in_data = wq[i];
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (acc) i++;
        budget++;
      end
    end
    in_valid = 1'b0;
    in_data = '0;
    checks++;
    if (i != limit) begin
      failures++;
      $display("FAIL driver_timeout got=%0d want=%0d", i, limit);
    end
  endtask

  // Write-master stand-in: done drops after the post-go cycle (unless held),
  // rises once every beat has been pushed.
  task automatic wm_model(input bit hold_high, input int p_target, input int d0);
    int budget;
    step();
    step();
    if (!hold_high) wm_done = 1'b0;
    budget = 0;
    while (push_count < p_target && budget < 3000) begin
      step();
      budget++;
    end
    checks++;
    if (push_count < p_target) begin
      failures++;
      $display("FAIL push_timeout got=%0d want=%0d", push_count, p_target);
    end
    if (hold_high) begin
      repeat (5) step();
      checks++;
      if (done_count != d0 || cfg_busy !== 1'b1) begin
        failures++;
        $display("FAIL early_done got done=%0d busy=%b want done=%0d busy=1",
                 done_count, cfg_busy, d0);
      end
      wm_done = 1'b0;
      repeat (2) step();
    end else begin
      repeat ($urandom_range(0, 3)) step();
    end
    checks++;
    if (done_count != d0 || cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL done_before_rise got done=%0d busy=%b want done=%0d busy=1",
               done_count, cfg_busy, d0);
    end
    wm_done = 1'b1;
    budget = 0;
    while (done_count == d0 && budget < 20) begin
      step();
      budget++;
    end
    checks++;
    if (done_count == d0) begin
      failures++;
      $display("FAIL done_timeout got=%0d want=%0d", done_count, d0 + 1);
    end
    checks++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got done=%b busy=%b want done=0 busy=0", cfg_done, cfg_busy);
    end
  endtask

  task automatic run_block(input logic [31:0] base, input int stall_at,
                           input bit hold_high, input bit extra_start);
    int n;
    int g0;
    int d0;
    int p0;
    int nbeats;
    n = wq.size();
    nbeats = (n + 3) / 4;
    g0 = go_count;
    d0 = done_count;
    p0 = push_count;
    build_model(base, n);
    pulse_start(base, 32'(n));
    checks++;
    if (cfg_busy !== 1'b1 || wm_go !== 1'b1) begin
      failures++;
      $display("FAIL start_go got busy=%b go=%b want busy=1 go=1", cfg_busy, wm_go);
    end
    fork
      drive_words(stall_at, n);
      wm_model(hold_high, p0 + nbeats, d0);
      if (extra_start) begin
        repeat (3) step();
        pulse_start(32'hDEAD_0000, 32'd100);
      end
    join
    step();
    checks++;
    if (go_count != g0 + 1 || push_count != p0 + nbeats || done_count != d0 + 1
        || exp_q.size() != 0) begin
      failures++;
      $display("FAIL block_counts got go=%0d push=%0d done=%0d left=%0d want go=%0d push=%0d done=%0d left=0",
               go_count - g0, push_count - p0, done_count - d0, exp_q.size(), 1, nbeats, 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_base = '0;
    cfg_words = '0;
    in_valid = 1'b0;
    in_data = '0;
    wm_done = 1'b1;
    wm_buffer_full = 1'b0;
    #3;
    checks++;
    if ({cfg_busy, cfg_done, in_ready, wm_go, wm_write_buffer, wm_fixed_location,
         wm_buffer_data, wm_base, wm_length} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b rdy=%b go=%b push=%b want all 0",
               cfg_busy, cfg_done, in_ready, wm_go, wm_write_buffer);
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (dbg_state !== ST_IDLE || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_seq8();
    wq.delete();
    for (int i = 1; i <= 8; i++) wq.push_back(32'(i));
    run_block(32'h0000_1000, -1, 1'b0, 1'b0);
  endtask

  task automatic test_partial5();
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(32'hA + 32'(i));
    run_block(32'h0000_2004, -1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_words();
    int g0;
    int p0;
    g0 = go_count;
    p0 = push_count;
    pulse_start(32'h0000_3000, 32'd0);
    checks++;
    if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || wm_go !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got done=%b busy=%b go=%b want done=1 busy=0 go=0",
               cfg_done, cfg_busy, wm_go);
    end
    step();
    step();
    checks++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b0 || go_count != g0 || push_count != p0) begin
      failures++;
      $display("FAIL zero_after got done=%b busy=%b go=%0d push=%0d want 0 0 0 0",
               cfg_done, cfg_busy, go_count - g0, push_count - p0);
    end
  endtask

  task automatic test_backpressure();
    wq.delete();
    for (int i = 0; i < 12; i++) wq.push_back($urandom);
    run_block(32'h0001_0000, 6, 1'b0, 1'b0);
  endtask

  task automatic test_done_guard();
    wq.delete();
    for (int i = 0; i < 9; i++) wq.push_back($urandom);
    run_block(32'h0002_0008, -1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(1, 20);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_block($urandom, ($urandom_range(0, 1) == 1) ? n / 2 : -1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_count;
    wq.delete();
    for (int i = 0; i < 12; i++) wq.push_back($urandom);
    build_model(32'h0004_0000, 12);
    pulse_start(32'h0004_0000, 32'd12);
    wm_done = 1'b0;
    drive_words(-1, 6);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_busy, cfg_done, in_ready, wm_go, wm_write_buffer,
         wm_buffer_data, wm_base, wm_length} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b rdy=%b base=%h len=%0d want all 0",
               cfg_busy, in_ready, wm_base, wm_length);
    end
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL midreset_beats got=%0d want=2 pending", exp_q.size());
    end
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    wm_done = 1'b1;
    step();
    checks++;
    if (dbg_state !== ST_IDLE || done_count != d0) begin
      failures++;
      $display("FAIL midreset_state got state=%0d done=%0d want state=%0d done=%0d",
               dbg_state, done_count, ST_IDLE, d0);
    end
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    run_block(32'h0005_0000, -1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_seq8();
    test_partial5();
    test_zero_words();
    test_backpressure();
    test_done_guard();
    test_random();
    test_reset_mid();
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
